// File: rtl/ask4_pkg.sv
// Shared definitions for the 4-ASK transmit path: FSM states, symbol coding
// and reference-level width.
package ask4_pkg;

  localparam int unsigned REF_W = 18;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_PAYLOAD  = 2'd2
  } state_e;

  localparam logic [1:0] SYM_P3 = 2'b01;
  localparam logic [1:0] SYM_P1 = 2'b00;
  localparam logic [1:0] SYM_M1 = 2'b10;
  localparam logic [1:0] SYM_M3 = 2'b11;

endpackage

// File: rtl/symbol_rate_counter.sv
// Free-running symbol timer. sym_strobe is registered; sym_strobe_next_c flags
// the cycle before a strobe so consumers can update in step with it.
module symbol_rate_counter #(
  parameter int unsigned SPS = 4
) (
  input  logic clk,
  input  logic reset_n,
  output logic sym_strobe,
  output logic sym_strobe_next_c
);

  localparam int unsigned CW = (SPS > 1) ? $clog2(SPS) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          strobe_q, strobe_d;

  always_comb begin
    cnt_d    = (cnt_q == CW'(SPS - 1)) ? '0 : cnt_q + CW'(1);
    strobe_d = (cnt_d == CW'(SPS - 1));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
    end
  end

  assign sym_strobe        = strobe_q;
  assign sym_strobe_next_c = strobe_d;

endmodule

// File: rtl/ask4_symbol_scheduler.sv
// Frame sequencer for the 4-ASK mapper: idle fill, preamble, payload symbols,
// and frame-boundary-only updates of the mapper reference level.
module ask4_symbol_scheduler
  import ask4_pkg::*;
#(
  parameter int unsigned      SPS          = 4,
  parameter int unsigned      PREAMBLE_LEN = 16,
  parameter logic [REF_W-1:0] REF_DEFAULT  = 18'd43690
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [7:0]       frame_len,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  input  logic             ref_wr,
  input  logic [REF_W-1:0] ref_wdata,
  output logic [1:0]       sym_out,
  output logic             sym_strobe,
  output logic [REF_W-1:0] reference_level,
  output logic             busy,
  output logic             frame_done,
  output logic             underrun
);

  localparam int unsigned PW = $clog2(PREAMBLE_LEN + 1);

  logic strobe_nx_c;

  symbol_rate_counter #(.SPS(SPS)) u_timer (
    .clk               (clk),
    .reset_n           (reset_n),
    .sym_strobe        (sym_strobe),
    .sym_strobe_next_c (strobe_nx_c)
  );

  state_e           state_q, state_d;
  logic             pend_q, pend_d;
  logic [7:0]       len_q, len_d;
  logic [PW-1:0]    pre_cnt_q, pre_cnt_d;
  logic [9:0]       pay_cnt_q, pay_cnt_d;
  logic [7:0]       acc_cnt_q, acc_cnt_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [7:0]       sh_q, sh_d;
  logic [2:0]       sh_cnt_q, sh_cnt_d;
  logic             idle_ph_q, idle_ph_d;
  logic [1:0]       sym_q, sym_d;
  logic             done_q, done_d;
  logic             under_q, under_d;
  logic             busy_q, busy_d;
  logic [REF_W-1:0] ref_q, ref_d;
  logic [REF_W-1:0] shadow_q, shadow_d;

  logic       start_acc, go, fire, pay_due;
  logic [1:0] idle_sym;

  assign byte_ready = (state_q != ST_IDLE) && !hold_full_q && (acc_cnt_q < len_q);
  assign start_acc  = start && (frame_len != 8'd0) && (state_q == ST_IDLE) && !pend_q;
  assign go         = strobe_nx_c && (state_q == ST_IDLE) && (pend_q || start_acc);
  assign fire       = byte_valid && byte_ready;
  assign idle_sym   = idle_ph_q ? SYM_M1 : SYM_P1;

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    len_d       = len_q;
    pre_cnt_d   = pre_cnt_q;
    pay_cnt_d   = pay_cnt_q;
    acc_cnt_d   = acc_cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    sh_d        = sh_q;
    sh_cnt_d    = sh_cnt_q;
    idle_ph_d   = idle_ph_q;
    sym_d       = sym_q;
    done_d      = 1'b0;
    under_d     = under_q;
    ref_d       = ref_q;
    shadow_d    = shadow_q;
    pay_due     = 1'b0;

    if (ref_wr) shadow_d = ref_wdata;

    if (start_acc) begin
      pend_d  = 1'b1;
      len_d   = frame_len;
      under_d = 1'b0;
    end

    if (fire) begin
      hold_d      = byte_in;
      hold_full_d = 1'b1;
      acc_cnt_d   = acc_cnt_q + 8'd1;
    end

    if (strobe_nx_c) begin
      case (state_q)
        ST_IDLE: begin
          // Transfer uses the pre-write shadow so a same-cycle write waits.
          ref_d = shadow_q;
          if (go) begin
            state_d     = ST_PREAMBLE;
            pend_d      = 1'b0;
            sym_d       = SYM_P3;
            pre_cnt_d   = PW'(1);
            pay_cnt_d   = 10'd0;
            acc_cnt_d   = 8'd0;
            sh_cnt_d    = 3'd0;
            hold_full_d = 1'b0;
          end else begin
            sym_d     = idle_sym;
            idle_ph_d = ~idle_ph_q;
          end
        end
        ST_PREAMBLE: begin
          if (pre_cnt_q < PW'(PREAMBLE_LEN)) begin
            sym_d     = pre_cnt_q[0] ? SYM_M3 : SYM_P3;
            pre_cnt_d = pre_cnt_q + PW'(1);
          end else begin
            state_d = ST_PAYLOAD;
            pay_due = 1'b1;
          end
        end
        ST_PAYLOAD: begin
          if (pay_cnt_q == {len_q, 2'b00}) begin
            state_d   = ST_IDLE;
            sym_d     = idle_sym;
            idle_ph_d = ~idle_ph_q;
            done_d    = 1'b1;
          end else begin
            pay_due = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Starved slots send 00 and do not advance the data-symbol count.
    if (pay_due) begin
      if (sh_cnt_q != 3'd0) begin
        sym_d     = sh_q[7:6];
        sh_d      = {sh_q[5:0], 2'b00};
        sh_cnt_d  = sh_cnt_q - 3'd1;
        pay_cnt_d = pay_cnt_q + 10'd1;
      end else if (hold_full_q) begin
        sym_d       = hold_q[7:6];
        sh_d        = {hold_q[5:0], 2'b00};
        sh_cnt_d    = 3'd3;
        hold_full_d = 1'b0;
        pay_cnt_d   = pay_cnt_q + 10'd1;
      end else begin
        sym_d   = SYM_P1;
        under_d = 1'b1;
      end
    end

    busy_d = (state_d != ST_IDLE) || pend_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      pend_q      <= 1'b0;
      len_q       <= 8'd0;
      pre_cnt_q   <= '0;
      pay_cnt_q   <= 10'd0;
      acc_cnt_q   <= 8'd0;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      sh_q        <= 8'd0;
      sh_cnt_q    <= 3'd0;
      idle_ph_q   <= 1'b0;
      sym_q       <= SYM_P1;
      done_q      <= 1'b0;
      under_q     <= 1'b0;
      busy_q      <= 1'b0;
      ref_q       <= REF_DEFAULT;
      shadow_q    <= REF_DEFAULT;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      len_q       <= len_d;
      pre_cnt_q   <= pre_cnt_d;
      pay_cnt_q   <= pay_cnt_d;
      acc_cnt_q   <= acc_cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sh_q        <= sh_d;
      sh_cnt_q    <= sh_cnt_d;
      idle_ph_q   <= idle_ph_d;
      sym_q       <= sym_d;
      done_q      <= done_d;
      under_q     <= under_d;
      busy_q      <= busy_d;
      ref_q       <= ref_d;
      shadow_q    <= shadow_d;
    end
  end

  assign sym_out         = sym_q;
  assign reference_level = ref_q;
  assign busy            = busy_q;
  assign frame_done      = done_q;
  assign underrun        = under_q;

endmodule
